uart_tx_feeder: RTL

- Byte-buffering stage directly upstream of the UART transmitter.
- Accepts bytes from the host-side logic into a synchronous FIFO, then issues them one at a time as a one-cycle start pulse plus data byte.
- Paces launches using the transmitter's busy flag, so no byte is dropped or launched while the transmitter is mid-frame.
- Sticky overflow flag reports host writes lost while the FIFO is full.

---
 rtl/uart_pkg.sv | 16 +
 rtl/sync_fifo.sv | 66 ++++++
 rtl/uart_tx_feeder.sv | 105 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit feeder.
package uart_pkg;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE,
      START,
      WAIT_BUSY,
      WAIT_DONE
   } tx_feed_state_t;

   // Cycles the feeder waits for the transmitter to raise busy after a launch.
   localparam int BUSY_TIMEOUT = 4;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and an explicit occupancy counter.
module sync_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      level_next;
   logic             wr_ok;
   logic             rd_ok;

   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_comb begin
      level_next = level;
      case ({wr_ok, rd_ok})
         2'b10:   level_next = level + (AW+1)'(1);
         2'b01:   level_next = level - (AW+1)'(1);
         default: level_next = level;
      endcase
   end

   // Occupancy is counted directly; pointers only address the array and wrap freely.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (rd_ok) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         level <= level_next;
         full  <= (level_next == (AW+1)'(DEPTH));
         empty <= (level_next == '0);
      end
   end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and launches them one at a time into a UART transmitter, paced by its busy flag.
module uart_tx_feeder
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst,
   input  byte_t       wr_data,
   input  logic        wr_en,
   output logic        full,
   output logic        empty,
   output logic [AW:0] level,
   output logic        overflow,
   input  logic        ovf_clr,
   output logic        tx_start,
   output byte_t       tx_data,
   input  logic        tx_busy
);

   localparam int CW = $clog2(BUSY_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(BUSY_TIMEOUT - 1);

   tx_feed_state_t state;
   tx_feed_state_t state_next;
   logic           pop;
   byte_t          fifo_rd_data;
   logic [CW-1:0]  busy_cnt;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (wr_data),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   // A launch only leaves IDLE once the transmitter is quiet, which also covers a frame still running across reset.
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && !tx_busy) begin
               pop        = 1'b1;
               state_next = START;
            end
         end
         START: begin
            state_next = WAIT_BUSY;
         end
         WAIT_BUSY: begin
            if (tx_busy) begin
               state_next = WAIT_DONE;
            end else if (busy_cnt == CNT_LAST) begin
               state_next = IDLE;
            end
         end
         WAIT_DONE: begin
            if (!tx_busy) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tx_start <= 1'b0;
         tx_data  <= '0;
         busy_cnt <= '0;
      end else begin
         state    <= state_next;
         tx_start <= (state_next == START);
         if (pop) begin
            tx_data <= fifo_rd_data;
         end
         busy_cnt <= (state == WAIT_BUSY) ? busy_cnt + CW'(1) : '0;
      end
   end

   // A lost write outranks a clear arriving in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (wr_en && full) begin
         overflow <= 1'b1;
      end else if (ovf_clr) begin
         overflow <= 1'b0;
      end
   end

endmodule
